// File: rtl/uart_rx_frame_pkg.sv
// Shared UART receive definitions: FSM states, legal oversampling ratios, parity encoding.
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic [5:0] Prescale8  = 6'd8;
    localparam logic [5:0] Prescale16 = 6'd16;
    localparam logic [5:0] Prescale32 = 6'd32;

    // Same encoding as the transmit side.
    typedef enum logic {
        ParEven = 1'b0,
        ParOdd  = 1'b1
    } par_typ_e;

    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            Prescale8, Prescale16, Prescale32: r = p;
            default:                           r = Prescale8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_frame_sampler.sv
// Bit-period counter and 2-of-3 majority vote around the bit centre.
module uart_rx_frame_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       start,
    input  logic       rx,
    input  logic [5:0] prescale,
    output logic       rx_bit,
    output logic       bit_done
);

    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [5:0] half;
    logic       s0_q, s1_q, bit_q;

    assign half = prescale >> 1;

    always_comb begin
        edge_cnt_d = 6'd0;
        // The IDLE cycle that saw the start edge is already count 0.
        if (start) begin
            edge_cnt_d = 6'd1;
        end else if (active) begin
            edge_cnt_d = (edge_cnt_q == prescale - 6'd1) ? 6'd0 : edge_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= 6'd0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (active && edge_cnt_q == half - 6'd1) s0_q <= rx;
            if (active && edge_cnt_q == half)        s1_q <= rx;
            if (active && edge_cnt_q == half + 6'd1) begin
                bit_q <= (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
            end
        end
    end

    assign rx_bit   = bit_q;
    assign bit_done = active && (edge_cnt_q == prescale - 6'd1);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start/data/parity/stop FSM, payload shift register, error pulses.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e             state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_fail_q, par_fail_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    par_typ_e              par_typ_q, par_typ_d;
    logic                  armed_q;
    logic                  start, rx_bit, bit_done, exp_par;

    // After reset, wait for the line to go high so only a true falling edge starts a frame.
    assign start   = (state_q == StIdle) && armed_q && !RX_IN;
    assign exp_par = (par_typ_q == ParOdd) ? ~(^shift_q) : ^shift_q;

    uart_rx_frame_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
        .active   (state_q != StIdle),
        .start    (start),
        .rx       (RX_IN),
        .prescale (prescale_q),
        .rx_bit   (rx_bit),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        par_fail_d = par_fail_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StStart;
                    prescale_d = legal_prescale(Prescale);
                    par_en_d   = PAR_EN;
                    par_typ_d  = par_typ_e'(PAR_TYP);
                    par_fail_d = 1'b0;
                    bit_cnt_d  = '0;
                end
            end
            StStart: begin
                if (bit_done) state_d = rx_bit ? StIdle : StData;
            end
            StData: begin
                if (bit_done) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = rx_bit;
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    par_fail_d = (rx_bit != exp_par);
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    state_d = StIdle;
                    se_d    = ~rx_bit;
                    pe_d    = par_fail_q;
                    dv_d    = rx_bit & ~par_fail_q;
                    if (rx_bit && !par_fail_q) p_data_d = shift_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            par_fail_q <= 1'b0;
            prescale_q <= Prescale8;
            par_en_q   <= 1'b0;
            par_typ_q  <= ParEven;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            par_fail_q <= par_fail_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
            armed_q    <= armed_q | RX_IN;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = pe_q;
    assign Stp_Err    = se_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of frames plus glitch, back-to-back and reset sequences.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_dv = 0, n_pe = 0, n_se = 0;
    int dv_cyc = 0, pe_cyc = 0, se_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Data_Valid) begin n_dv <= n_dv + 1; dv_cyc <= cyc; end
        if (Par_Err)    begin n_pe <= n_pe + 1; pe_cyc <= cyc; end
        if (Stp_Err)    begin n_se <= n_se + 1; se_cyc <= cyc; end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b, input int blen, input logic glitch);
        for (int j = 0; j < blen; j++) begin
            RX_IN = (glitch && j == blen / 2) ? ~b : b;
            tick();
        end
    endtask

    task automatic send_frame(input int blen, input logic [7:0] data, input logic pen,
                              input logic pbit, input logic stop, input int glitch_bit);
        drive_bit(1'b0, blen, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i], blen, glitch_bit == i);
        if (pen) drive_bit(pbit, blen, 1'b0);
        drive_bit(stop, blen, 1'b0);
    endtask

    typedef struct {
        logic [5:0] pre;
        int         blen;
        logic       pen;
        logic       ptyp;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        int         glitch;
        int         e_dv;
        int         e_pe;
        int         e_se;
        logic [7:0] e_pdata;
        int         e_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int s_dv, s_pe, s_se, c0;

        //        pre  blen pen ptyp data   pbit stop glt dv pe se pdata  lat
        vecs[0] = '{6'd8,  8,  0, 0, 8'hA5, 0, 1, -1, 1, 0, 0, 8'hA5, 80};
        vecs[1] = '{6'd16, 16, 1, 0, 8'h3C, 1, 1, -1, 0, 1, 0, 8'hA5, 0};
        vecs[2] = '{6'd32, 32, 1, 1, 8'h01, 0, 0, -1, 0, 0, 1, 8'hA5, 0};
        vecs[3] = '{6'd16, 16, 0, 0, 8'hFF, 0, 1,  3, 1, 0, 0, 8'hFF, 160};
        vecs[4] = '{6'd12, 8,  0, 0, 8'hC3, 0, 1, -1, 1, 0, 0, 8'hC3, 80};
        vecs[5] = '{6'd32, 32, 1, 1, 8'h80, 0, 1, -1, 1, 0, 0, 8'h80, 352};
        vecs[6] = '{6'd8,  8,  1, 0, 8'h07, 1, 1, -1, 1, 0, 0, 8'h07, 88};
        vecs[7] = '{6'd8,  8,  1, 0, 8'h00, 1, 0, -1, 0, 1, 1, 8'h07, 0};

        rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) tick();
        check("reset_pdata", P_DATA, 0);
        check("reset_dv", Data_Valid, 0);
        check("reset_pe", Par_Err, 0);
        check("reset_se", Stp_Err, 0);
        rst = 1'b0;
        idle(4);

        for (int v = 0; v < 8; v++) begin
            Prescale = vecs[v].pre; PAR_EN = vecs[v].pen; PAR_TYP = vecs[v].ptyp;
            idle(4);
            s_dv = n_dv; s_pe = n_pe; s_se = n_se;
            c0 = cyc;
            send_frame(vecs[v].blen, vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop,
                       vecs[v].glitch);
            idle(6);
            check($sformatf("v%0d_dv", v), n_dv - s_dv, vecs[v].e_dv);
            check($sformatf("v%0d_pe", v), n_pe - s_pe, vecs[v].e_pe);
            check($sformatf("v%0d_se", v), n_se - s_se, vecs[v].e_se);
            check($sformatf("v%0d_pdata", v), P_DATA, vecs[v].e_pdata);
            if (vecs[v].e_lat != 0) check($sformatf("v%0d_lat", v), dv_cyc - c0, vecs[v].e_lat);
            if (vecs[v].e_pe != 0 && vecs[v].e_se != 0) check("v_err_same_cycle", se_cyc, pe_cyc);
        end

        // Short low pulse on the line is a false start.
        Prescale = 6'd8; PAR_EN = 1'b0;
        idle(4);
        s_dv = n_dv; s_pe = n_pe; s_se = n_se;
        RX_IN = 1'b0;
        repeat (2) tick();
        idle(12);
        check("glitch_dv", n_dv - s_dv, 0);
        check("glitch_pe", n_pe - s_pe, 0);
        check("glitch_se", n_se - s_se, 0);
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        check("after_glitch_dv", n_dv - s_dv, 1);
        check("after_glitch_pdata", P_DATA, 8'h5A);

        // Back-to-back frames, then reset in the middle of a third.
        s_dv = n_dv; s_pe = n_pe; s_se = n_se;
        send_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        check("b2b_dv1", Data_Valid, 1);
        check("b2b_pdata1", P_DATA, 8'h11);
        send_frame(8, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        check("b2b_dv2", Data_Valid, 1);
        check("b2b_pdata2", P_DATA, 8'h22);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        drive_bit(1'b1, 8, 1'b0);
        rst = 1'b1; RX_IN = 1'b1;
        tick();
        check("rst_pdata", P_DATA, 0);
        check("rst_dv", Data_Valid, 0);
        check("rst_pe", Par_Err, 0);
        check("rst_se", Stp_Err, 0);
        rst = 1'b0;
        idle(40);
        check("abort_dv_count", n_dv - s_dv, 2);
        check("abort_pe_count", n_pe - s_pe, 0);
        check("abort_se_count", n_se - s_se, 0);
        check("abort_pdata", P_DATA, 0);
        send_frame(8, 8'h33, 1'b0, 1'b0, 1'b1, -1);
        idle(4);
        check("resume_dv_count", n_dv - s_dv, 3);
        check("resume_pdata", P_DATA, 8'h33);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 RX_IN  input  1  serial line; idle high, synchronised upstream.
REQ-005 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  received payload, LSB first on the line.
REQ-009 Data_Valid  output  1  one-cycle pulse when an error-free frame completes.
REQ-010 Par_Err  output  1  one-cycle pulse on parity mismatch.
REQ-011 Stp_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 Frame order SHALL be 1 start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and 1 stop bit (1).
REQ-014 Each bit period SHALL be Prescale clk cycles, counted by edge_cnt from 0 to Prescale-1.
REQ-015 In IDLE, a cycle with RX_IN=0 SHALL move the FSM to START, and that cycle SHALL count as edge_cnt=0.
REQ-016 Each bit SHALL be the 2-of-3 majority of RX_IN at edge_cnt = Prescale/2-1, Prescale/2, and Prescale/2+1.
REQ-017 A START bit that resolves to 1 SHALL be treated as a glitch: return to IDLE at edge_cnt=Prescale-1 with no output pulse.
REQ-018 DATA SHALL shift DATA_WIDTH resolved bits into a shift register; bit_cnt SHALL wrap to 0 on exit.
REQ-019 DATA SHALL go to PARITY when PAR_EN=1, otherwise to STOP.
REQ-020 Expected parity SHALL be the XOR of the data bits for even parity and the XNOR for odd parity; a mismatch with the received parity bit SHALL set an internal parity-fail flag.
REQ-021 At edge_cnt=Prescale-1 of STOP, the block SHALL evaluate the frame and return to IDLE.
REQ-022 Evaluation: pulse Stp_Err if stop resolved to 0; pulse Par_Err if the parity-fail flag is set; pulse Data_Valid only if neither error applies.
REQ-023 All pulses SHALL occur on the same cycle and last exactly one cycle.
REQ-024 P_DATA SHALL update only on a Data_Valid cycle and hold otherwise, including across errored frames.
REQ-025 PAR_EN, PAR_TYP, and Prescale SHALL be captured on the START entry and held for the whole frame.
REQ-026 An illegal Prescale value SHALL be treated as 8.
REQ-027 Frame-to-frame latency: when RX_IN is low on the first IDLE cycle after STOP, START SHALL be entered on that cycle, with no dead cycle.

Reset
REQ-028 While rst=1 at a clk edge: state SHALL go to IDLE, all counters and the shift register SHALL clear, P_DATA SHALL be 0, and Data_Valid, Par_Err, and Stp_Err SHALL be 0.
REQ-029 Reset mid-frame SHALL abort the frame with no pulse; reception SHALL resume on the next falling edge after reset is released.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the legal Prescale constants (8/16/32), and the parity-type encoding shared with the transmit side.
REQ-031 Sub-module uart_rx_sampler SHALL contain edge_cnt and the majority-vote logic, and SHALL output the resolved bit plus a bit_done strobe; the FSM, shift register, and parity check SHALL stay in the top.

Verification
REQ-032 Prescale=8, PAR_EN=0, frame 0xA5 -> one Data_Valid pulse, P_DATA=0xA5, 10x8=80 cycles after the start edge, no errors.
REQ-033 Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 1 (wrong) -> Par_Err pulse, no Data_Valid, P_DATA unchanged.
REQ-034 Prescale=32, PAR_TYP=1, data 0x01 with correct parity 0 but stop bit 0 -> Stp_Err pulse only, no Data_Valid.
REQ-035 Prescale=8, RX_IN low for 2 cycles then high -> return to IDLE, no pulses; a following valid 0x5A frame is received correctly.
REQ-036 Prescale=16, one inverted RX_IN cycle at sample point Prescale/2 of data bit 3 in frame 0xFF -> majority vote recovers P_DATA=0xFF.
REQ-037 Prescale=8, back-to-back frames 0x11 and 0x22, then rst=1 for 1 cycle mid-third frame -> two Data_Valid pulses with correct data, then no pulse for the aborted frame and all outputs 0 after reset.
